// File: rtl/vc_rr_queue_arb.sv
// Round-robin arbiter onto one enqueue port; zero-cycle comb in->out, out_rdy low holds grant and state.
// `define VC_RR_ARB_PKTLOCK_EN to keep a grant across multi-beat packets until in_last.
module vc_rr_queue_arb #(
    parameter int DATA_SZ = 32,
    parameter int NREQ    = 4,
    parameter int SEL_SZ  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ*DATA_SZ-1:0] in_bits,
    input  logic [NREQ-1:0]         in_last,
    input  logic [NREQ-1:0]         in_val,
    output logic [NREQ-1:0]         in_rdy,
    output logic [DATA_SZ-1:0]      out_bits,
    output logic                    out_last,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [SEL_SZ-1:0]       out_sel
);

    logic [SEL_SZ-1:0]  prio_q, prio_d;
    logic [SEL_SZ-1:0]  scan_idx;
    logic [SEL_SZ-1:0]  grant;
    logic               sel_val;
    logic               sel_last;
    logic [DATA_SZ-1:0] sel_bits;
    logic               xfer;
    int                 j;

    // Walk the rotation backwards so the last hit written is the first in priority order.
    always_comb begin
        scan_idx = '0;
        j        = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(prio_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (in_val[j]) begin
                scan_idx = SEL_SZ'(j);
            end
        end
    end

`ifdef VC_RR_ARB_PKTLOCK_EN
    logic              locked_q, locked_d;
    logic [SEL_SZ-1:0] lock_idx_q, lock_idx_d;

    assign grant = locked_q ? lock_idx_q : scan_idx;
`else
    assign grant = scan_idx;
`endif

    always_comb begin
        sel_val  = 1'b0;
        sel_last = 1'b0;
        sel_bits = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (SEL_SZ'(i) == grant) begin
                sel_val  = in_val[i];
                sel_last = in_last[i];
                sel_bits = in_bits[i*DATA_SZ +: DATA_SZ];
            end
        end
    end

    assign out_val  = sel_val && !reset;
    assign out_sel  = out_val ? grant : '0;
    assign out_bits = out_val ? sel_bits : '0;
    assign out_last = out_val && sel_last;
    assign xfer     = out_val && out_rdy;

    always_comb begin
        in_rdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            in_rdy[i] = out_rdy && out_val && (SEL_SZ'(i) == grant);
        end
    end

    always_comb begin
        prio_d = prio_q;
`ifdef VC_RR_ARB_PKTLOCK_EN
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (xfer) begin
            if (out_last) begin
                prio_d   = (int'(grant) == NREQ - 1) ? '0 : grant + SEL_SZ'(1);
                locked_d = 1'b0;
            end else begin
                locked_d   = 1'b1;
                lock_idx_d = grant;
            end
        end
`else
        if (xfer) begin
            prio_d = (int'(grant) == NREQ - 1) ? '0 : grant + SEL_SZ'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

`ifdef VC_RR_ARB_PKTLOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`endif

endmodule
